// File: rtl/gf_mult_frontend_if.sv
// rtl/gf_mult_frontend_if.sv - stream and multiplier bus bundle for gf_mult_frontend
//
// Purpose: groups the operand input stream, result output stream and the
// GF(2^163) multiplier bus into one interface.
// Signals:
//   in_valid/in_ready/in_data[31:0]             operand words, LS word first
//   mul_A/mul_B[162:0], mul_start               operands and start to multiplier
//   mul_Z[162:0], mul_done                      product and completion pulse
//   out_valid/out_ready/out_data[31:0]/out_last result words, LS word first
// Modports:
//   slave  - the frontend block
//   master - the environment (source, sink and multiplier)
interface gf_mult_frontend_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [162:0] mul_A;
  logic [162:0] mul_B;
  logic         mul_start;
  logic [162:0] mul_Z;
  logic         mul_done;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;

  modport slave (
    input  in_valid, in_data, mul_Z, mul_done, out_ready,
    output in_ready, mul_A, mul_B, mul_start, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, mul_Z, mul_done, out_ready,
    input  in_ready, mul_A, mul_B, mul_start, out_valid, out_data, out_last
  );
endinterface

// File: rtl/gf_mult_frontend.sv
// rtl/gf_mult_frontend.sv - word-serial load/unload frontend for a GF(2^163) multiplier
//
// Purpose: assembles two 163-bit operands from six 32-bit words each, holds
// the multiplier start until its done pulse (or a timeout), then streams the
// 163-bit product back out as six 32-bit words.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   bus   - gf_mult_frontend_if.slave (input stream, multiplier bus, output stream)
//   busy  - high in every state except LOAD_A
//   err   - sticky timeout flag, cleared by the next accepted input word
// Parameter:
//   TIMEOUT - maximum number of cycles spent waiting in RUN
module gf_mult_frontend #(
  parameter int TIMEOUT = 400
) (
  input  logic                clk,
  input  logic                rst,
  gf_mult_frontend_if.slave   bus,
  output logic                busy,
  output logic                err
);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, RUN, UNLOAD} state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t        state, state_nx;
  logic [2:0]    wcnt, wcnt_nx;
  logic [TW-1:0] timer;
  logic [162:0]  op_a, op_b, res;
  logic [191:0]  res_ext;
  logic [31:0]   res_word;
  logic          last_word;
  logic          in_rdy, start, ov, ol;
  logic [31:0]   od;
  logic          timed_out;
  logic          in_xfer;

  // Word k lands in bits [32k+31:32k]; word 5 only supplies the top 3 bits.
  function automatic logic [162:0] put_word(input logic [162:0] op,
                                            input logic [2:0]   k,
                                            input logic [31:0]  d);
    logic [162:0] r;
    r = op;
    case (k)
      3'd0: r[31:0]    = d;
      3'd1: r[63:32]   = d;
      3'd2: r[95:64]   = d;
      3'd3: r[127:96]  = d;
      3'd4: r[159:128] = d;
      3'd5: r[162:160] = d[2:0];
      default: r = op;
    endcase
    return r;
  endfunction

  assign last_word = (wcnt == 3'd5);
  // Zero-extend so word 5 naturally reads zeros above bit 162.
  assign res_ext   = {29'b0, res};
  assign res_word  = res_ext[{wcnt, 5'b0} +: 32];
  assign in_xfer   = bus.in_valid && in_rdy;

  always_comb begin
    state_nx  = state;
    wcnt_nx   = wcnt;
    in_rdy    = 1'b0;
    start     = 1'b0;
    ov        = 1'b0;
    od        = 32'd0;
    ol        = 1'b0;
    timed_out = 1'b0;
    case (state)
      LOAD_A: begin
        in_rdy = 1'b1;
        if (bus.in_valid) begin
          wcnt_nx = last_word ? 3'd0 : wcnt + 3'd1;
          if (last_word) state_nx = LOAD_B;
        end
      end
      LOAD_B: begin
        in_rdy = 1'b1;
        if (bus.in_valid) begin
          wcnt_nx = last_word ? 3'd0 : wcnt + 3'd1;
          if (last_word) state_nx = RUN;
        end
      end
      RUN: begin
        start = 1'b1;
        if (bus.mul_done) begin
          state_nx = UNLOAD;
        end else if (timer == T_LAST) begin
          state_nx  = LOAD_A;
          timed_out = 1'b1;
        end
      end
      UNLOAD: begin
        ov = 1'b1;
        od = res_word;
        ol = last_word;
        if (bus.out_ready) begin
          wcnt_nx = last_word ? 3'd0 : wcnt + 3'd1;
          if (last_word) state_nx = LOAD_A;
        end
      end
      default: begin
        state_nx = LOAD_A;
        wcnt_nx  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD_A;
      wcnt  <= 3'd0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      timer <= '0;
      err   <= 1'b0;
    end else begin
      if (state == LOAD_A && bus.in_valid) op_a <= put_word(op_a, wcnt, bus.in_data);
      if (state == LOAD_B && bus.in_valid) op_b <= put_word(op_b, wcnt, bus.in_data);
      // A done pulse outside RUN never reaches the result register.
      if (state == RUN && bus.mul_done) res <= bus.mul_Z;
      // Timer restarts from zero on every entry to RUN.
      timer <= (state == RUN && state_nx == RUN) ? timer + 1'b1 : '0;
      if (timed_out)    err <= 1'b1;
      else if (in_xfer) err <= 1'b0;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.mul_A     = op_a;
  assign bus.mul_B     = op_b;
  assign bus.mul_start = start;
  assign bus.out_valid = ov;
  assign bus.out_data  = od;
  assign bus.out_last  = ol;
  assign busy          = (state != LOAD_A);

endmodule
